rob_superscalar: RTL and testbench

// Multi-lane reorder buffer for the OoO core. Accepts up to DISP_W in-order allocations per cycle

---
 rtl/rob_superscalar.sv | 220 ++++++++++++++++++++++
 tb/tb_rob_superscalar.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_superscalar.sv
// ----------------------------------------------------------------------------
// rob_superscalar
// Multi-lane reorder buffer for the out-of-order core. Rename/dispatch
// allocates up to DISP_W entries per cycle in program order, the CDB ports
// mark entries done, and up to COMMIT_W done entries retire in order towards
// the RRAT / free list. A mispredicted control op retires normally and
// squashes every younger entry in the same cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   disp_valid_i        per-lane allocate request (contiguous from lane 0)
//   disp_rd_i/pd_i      arch / phys destination per dispatch lane
//   disp_ready_o        all DISP_W lanes may allocate this cycle
//   disp_tag_o          tag handed to dispatch lane k (tail + k)
//   cdb_valid_i         completion strobe per CDB port
//   cdb_tag_i           tag of the completing entry (wrap bit in MSB)
//   cdb_result_i        result value per port
//   cdb_regf_we_i       completing entry writes a register
//   cdb_mispredict_i    completing entry is a mispredicted control op
//   commit_valid_o      commit lane retires this cycle
//   commit_rd_o/pd_o    retiring arch / phys destination
//   commit_result_o     retiring result
//   commit_regf_we_o    RRAT update enable
//   flush_out_o         younger-than-branch squash this cycle
//   occupancy_o         registered live-entry count, 0..DEPTH
// ----------------------------------------------------------------------------
module rob_superscalar #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int DISP_W   = 2,
    parameter int COMMIT_W = 2,
    parameter int CDB_N    = 2,
    parameter int A_REG_W  = 5,
    parameter int P_REG_W  = 6,
    parameter int DATA_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DISP_W-1:0]             disp_valid_i,
    input  logic [DISP_W*A_REG_W-1:0]     disp_rd_i,
    input  logic [DISP_W*P_REG_W-1:0]     disp_pd_i,
    output logic                          disp_ready_o,
    output logic [DISP_W*(IDX_W+1)-1:0]   disp_tag_o,
    input  logic [CDB_N-1:0]              cdb_valid_i,
    input  logic [CDB_N*(IDX_W+1)-1:0]    cdb_tag_i,
    input  logic [CDB_N*DATA_W-1:0]       cdb_result_i,
    input  logic [CDB_N-1:0]              cdb_regf_we_i,
    input  logic [CDB_N-1:0]              cdb_mispredict_i,
    output logic [COMMIT_W-1:0]           commit_valid_o,
    output logic [COMMIT_W*A_REG_W-1:0]   commit_rd_o,
    output logic [COMMIT_W*P_REG_W-1:0]   commit_pd_o,
    output logic [COMMIT_W*DATA_W-1:0]    commit_result_o,
    output logic [COMMIT_W-1:0]           commit_regf_we_o,
    output logic                          flush_out_o,
    output logic [IDX_W:0]                occupancy_o
);

    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so that full and empty are distinct
    // and so that stale CDB tags from a previous lap can be rejected.
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   occ_q, occ_d;

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   done_q, done_d;
    logic [DEPTH-1:0]   wrap_q;
    logic [DEPTH-1:0]   regf_we_q;
    logic [DEPTH-1:0]   mispred_q;
    logic [A_REG_W-1:0] rd_q     [DEPTH];
    logic [P_REG_W-1:0] pd_q     [DEPTH];
    logic [DATA_W-1:0]  result_q [DEPTH];

    logic [IDX_W+1:0]   free_slots;
    logic [PTR_W-1:0]   disp_ptr [DISP_W];
    logic [DISP_W-1:0]  alloc_en;
    logic [PTR_W-1:0]   alloc_cnt;

    logic [PTR_W-1:0]   cdb_tag_w [CDB_N];
    logic [IDX_W-1:0]   cdb_slot  [CDB_N];
    logic [CDB_N-1:0]   cdb_hit;

    logic [PTR_W-1:0]   commit_ptr  [COMMIT_W];
    logic [IDX_W-1:0]   commit_slot [COMMIT_W];
    logic [PTR_W-1:0]   commit_cnt;
    logic               chain_ok;

    assign occupancy_o = occ_q;

    // Ready is derived from the registered count only, so slots freed by a
    // commit in this cycle become usable one cycle later.
    assign free_slots   = (IDX_W+2)'(DEPTH) - {1'b0, occ_q};
    assign disp_ready_o = (free_slots >= (IDX_W+2)'(DISP_W));

    // Dispatch lanes map onto consecutive tags starting at tail. A flush
    // cycle swallows any dispatch so the new tail equals the new head.
    always_comb begin
        alloc_cnt = '0;
        for (int k = 0; k < DISP_W; k++) begin
            disp_ptr[k]                  = tail_q + PTR_W'(k);
            disp_tag_o[k*PTR_W +: PTR_W] = disp_ptr[k];
            alloc_en[k]                  = disp_valid_i[k] & disp_ready_o & ~flush_out_o;
            alloc_cnt                    = alloc_cnt + PTR_W'(alloc_en[k]);
        end
    end

    // A completion only lands when the slot is live and its wrap bit matches
    // the tag's, so a late result from a squashed or already-retired lap is
    // silently dropped.
    always_comb begin
        for (int p = 0; p < CDB_N; p++) begin
            cdb_tag_w[p] = cdb_tag_i[p*PTR_W +: PTR_W];
            cdb_slot[p]  = cdb_tag_w[p][IDX_W-1:0];
            cdb_hit[p]   = cdb_valid_i[p] & valid_q[cdb_slot[p]] &
                           (wrap_q[cdb_slot[p]] == cdb_tag_w[p][IDX_W]);
        end
    end

    // Commit lanes form an in-order chain: a lane retires only if every older
    // lane retires too, and a mispredicting lane retires but breaks the chain.
    always_comb begin
        chain_ok         = 1'b1;
        commit_cnt       = '0;
        flush_out_o      = 1'b0;
        commit_valid_o   = '0;
        commit_rd_o      = '0;
        commit_pd_o      = '0;
        commit_result_o  = '0;
        commit_regf_we_o = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            commit_ptr[k]  = head_q + PTR_W'(k);
            commit_slot[k] = commit_ptr[k][IDX_W-1:0];
            commit_valid_o[k] = chain_ok & (PTR_W'(k) < occ_q) &
                                valid_q[commit_slot[k]] & done_q[commit_slot[k]];
            commit_rd_o[k*A_REG_W +: A_REG_W]    = rd_q[commit_slot[k]];
            commit_pd_o[k*P_REG_W +: P_REG_W]    = pd_q[commit_slot[k]];
            commit_result_o[k*DATA_W +: DATA_W]  = result_q[commit_slot[k]];
            commit_regf_we_o[k]                  = regf_we_q[commit_slot[k]];
            if (commit_valid_o[k]) begin
                commit_cnt = commit_cnt + PTR_W'(1);
                if (mispred_q[commit_slot[k]]) begin
                    flush_out_o = 1'b1;
                end
            end
            chain_ok = commit_valid_o[k] & ~mispred_q[commit_slot[k]];
        end
    end

    // Next-state for the per-entry status bits and the pointers. Allocation
    // targets free slots and commit targets live ones, so the two never hit
    // the same slot; a flush wipes everything that is still live.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        for (int k = 0; k < DISP_W; k++) begin
            if (alloc_en[k]) begin
                valid_d[disp_ptr[k][IDX_W-1:0]] = 1'b1;
                done_d[disp_ptr[k][IDX_W-1:0]]  = 1'b0;
            end
        end
        for (int p = 0; p < CDB_N; p++) begin
            if (cdb_hit[p]) begin
                done_d[cdb_slot[p]] = 1'b1;
            end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid_o[k]) begin
                valid_d[commit_slot[k]] = 1'b0;
                done_d[commit_slot[k]]  = 1'b0;
            end
        end
        head_d = head_q + commit_cnt;
        if (flush_out_o) begin
            valid_d = '0;
            done_d  = '0;
            tail_d  = head_d;
            occ_d   = '0;
        end else begin
            tail_d  = tail_q + alloc_cnt;
            occ_d   = occ_q + alloc_cnt - commit_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload storage needs no reset: it is only observed through entries
    // whose valid/done bits are set, and those are always written first.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DISP_W; k++) begin
            if (alloc_en[k]) begin
                rd_q[disp_ptr[k][IDX_W-1:0]]   <= disp_rd_i[k*A_REG_W +: A_REG_W];
                pd_q[disp_ptr[k][IDX_W-1:0]]   <= disp_pd_i[k*P_REG_W +: P_REG_W];
                wrap_q[disp_ptr[k][IDX_W-1:0]] <= disp_ptr[k][IDX_W];
            end
        end
        for (int p = 0; p < CDB_N; p++) begin
            if (cdb_hit[p]) begin
                result_q[cdb_slot[p]]  <= cdb_result_i[p*DATA_W +: DATA_W];
                regf_we_q[cdb_slot[p]] <= cdb_regf_we_i[p];
                mispred_q[cdb_slot[p]] <= cdb_mispredict_i[p];
            end
        end
    end

endmodule

// File: tb/tb_rob_superscalar.sv
// ----------------------------------------------------------------------------
// tb_rob_superscalar
// Directed self-checking bench for rob_superscalar with the default
// parameters (DEPTH 16, two dispatch / commit / CDB lanes). Walks through
// fill-to-full, in-order commit, out-of-order completion, mispredict flush,
// pointer wrap with a stale tag, and reset with live entries.
// ----------------------------------------------------------------------------
module tb_rob_superscalar;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int TAG_W = IDX_W + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dispValid;
    logic [9:0]  dispRd;
    logic [11:0] dispPd;
    logic        dispReady;
    logic [9:0]  dispTag;
    logic [1:0]  cdbValid;
    logic [9:0]  cdbTag;
    logic [63:0] cdbResult;
    logic [1:0]  cdbRegfWe;
    logic [1:0]  cdbMispredict;
    logic [1:0]  commitValid;
    logic [9:0]  commitRd;
    logic [11:0] commitPd;
    logic [63:0] commitResult;
    logic [1:0]  commitRegfWe;
    logic        flushOut;
    logic [4:0]  occupancy;

    int checks = 0;
    int errors = 0;

    logic [4:0]  t0, t1;
    logic [5:0]  p0, p1;

    always #5 clk = ~clk;

    rob_superscalar #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DISP_W(2), .COMMIT_W(2), .CDB_N(2),
        .A_REG_W(5), .P_REG_W(6), .DATA_W(32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .disp_valid_i     (dispValid),
        .disp_rd_i        (dispRd),
        .disp_pd_i        (dispPd),
        .disp_ready_o     (dispReady),
        .disp_tag_o       (dispTag),
        .cdb_valid_i      (cdbValid),
        .cdb_tag_i        (cdbTag),
        .cdb_result_i     (cdbResult),
        .cdb_regf_we_i    (cdbRegfWe),
        .cdb_mispredict_i (cdbMispredict),
        .commit_valid_o   (commitValid),
        .commit_rd_o      (commitRd),
        .commit_pd_o      (commitPd),
        .commit_result_o  (commitResult),
        .commit_regf_we_o (commitRegfWe),
        .flush_out_o      (flushOut),
        .occupancy_o      (occupancy)
    );

    // Drive every DUT input for the coming clock edge.
    task automatic applyStimulus(input logic [1:0] dv, input logic [9:0] drd,
                                 input logic [11:0] dpd, input logic [1:0] cv,
                                 input logic [9:0] ctag, input logic [63:0] cres,
                                 input logic [1:0] cwe, input logic [1:0] cmp);
        dispValid     = dv;
        dispRd        = drd;
        dispPd        = dpd;
        cdbValid      = cv;
        cdbTag        = ctag;
        cdbResult     = cres;
        cdbRegfWe     = cwe;
        cdbMispredict = cmp;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
    endtask

    // Advance one edge and settle just after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_occ",      64'(occupancy),   64'd0);
        checkOutput("rst_ready",    64'(dispReady),   64'd1);
        checkOutput("rst_cvalid",   64'(commitValid), 64'd0);
        checkOutput("rst_flush",    64'(flushOut),    64'd0);
        checkOutput("rst_disp_tag", 64'(dispTag),     64'({5'd1, 5'd0}));

        // Fill: eight cycles of two allocations, rd = tag, pd = tag + 32
        for (int i = 0; i < 8; i++) begin
            t0 = 5'(2*i);
            t1 = 5'(2*i + 1);
            p0 = 6'(2*i + 32);
            p1 = 6'(2*i + 33);
            checkOutput("fill_ready", 64'(dispReady), 64'd1);
            checkOutput("fill_tag",   64'(dispTag),   64'({t1, t0}));
            applyStimulus(2'b11, {t1, t0}, {p1, p0}, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
            tick();
        end
        checkOutput("full_occ",   64'(occupancy), 64'd16);
        checkOutput("full_ready", 64'(dispReady), 64'd0);

        // Dispatch while full is ignored
        tick();
        checkOutput("full_ign_occ", 64'(occupancy), 64'd16);
        checkOutput("full_ign_tag", 64'(dispTag),   64'({5'd17, 5'd16}));

        // Complete tags 0 and 1 on both ports
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b11, {5'd1, 5'd0},
                      {32'h1111_0001, 32'h1111_0000}, 2'b01, 2'b00);
        tick();
        idle();
        checkOutput("c01_valid",  64'(commitValid),  64'd3);
        checkOutput("c01_rd",     64'(commitRd),     64'({5'd1, 5'd0}));
        checkOutput("c01_pd",     64'(commitPd),     64'({6'd33, 6'd32}));
        checkOutput("c01_result", commitResult,      {32'h1111_0001, 32'h1111_0000});
        checkOutput("c01_we",     64'(commitRegfWe), 64'd1);
        checkOutput("c01_flush",  64'(flushOut),     64'd0);
        tick();
        checkOutput("after_c01_occ",   64'(occupancy),   64'd14);
        checkOutput("after_c01_ready", 64'(dispReady),   64'd1);
        checkOutput("after_c01_cv",    64'(commitValid), 64'd0);

        // Younger entry completes first: nothing may retire
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b01, {5'd0, 5'd3},
                      {32'd0, 32'h3333_3333}, 2'b01, 2'b00);
        tick();
        idle();
        checkOutput("ooo_block_cv", 64'(commitValid), 64'd0);
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b10, {5'd2, 5'd0},
                      {32'h2222_2222, 32'd0}, 2'b10, 2'b00);
        tick();
        idle();
        checkOutput("ooo_pair_cv",     64'(commitValid),  64'd3);
        checkOutput("ooo_pair_rd",     64'(commitRd),     64'({5'd3, 5'd2}));
        checkOutput("ooo_pair_result", commitResult,      {32'h3333_3333, 32'h2222_2222});
        tick();
        checkOutput("ooo_after_occ", 64'(occupancy), 64'd12);

        // Mispredict flush: fresh ROB with tags 0..5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t0 = 5'(2*i);
            t1 = 5'(2*i + 1);
            p0 = 6'(2*i + 32);
            p1 = 6'(2*i + 33);
            applyStimulus(2'b11, {t1, t0}, {p1, p0}, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
            tick();
        end
        checkOutput("mp_occ6", 64'(occupancy), 64'd6);
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b11, {5'd3, 5'd1},
                      {32'hB3, 32'hB1}, 2'b11, 2'b00);
        tick();
        checkOutput("mp_wait_cv", 64'(commitValid), 64'd0);
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b11, {5'd2, 5'd0},
                      {32'hB2, 32'hB0}, 2'b11, 2'b10);
        tick();
        idle();
        // Cycle A
        checkOutput("mpA_cv",    64'(commitValid), 64'd3);
        checkOutput("mpA_rd",    64'(commitRd),    64'({5'd1, 5'd0}));
        checkOutput("mpA_flush", 64'(flushOut),    64'd0);
        tick();
        // Cycle B, with a dispatch attempt that must be discarded
        applyStimulus(2'b11, {5'd9, 5'd8}, {6'd9, 6'd8}, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
        checkOutput("mpB_cv",     64'(commitValid),     64'd1);
        checkOutput("mpB_flush",  64'(flushOut),        64'd1);
        checkOutput("mpB_rd",     64'(commitRd[4:0]),   64'd2);
        checkOutput("mpB_result", 64'(commitResult[31:0]), 64'h0000_00B2);
        tick();
        // Cycle C, late completion to squashed tag 3
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b01, {5'd0, 5'd3},
                      {32'd0, 32'hDEAD}, 2'b01, 2'b00);
        checkOutput("mpC_occ",   64'(occupancy),   64'd0);
        checkOutput("mpC_tag",   64'(dispTag),     64'({5'd4, 5'd3}));
        checkOutput("mpC_cv",    64'(commitValid), 64'd0);
        checkOutput("mpC_flush", 64'(flushOut),    64'd0);
        tick();
        idle();
        checkOutput("late_cdb_cv",  64'(commitValid), 64'd0);
        checkOutput("late_cdb_occ", 64'(occupancy),   64'd0);
        applyStimulus(2'b01, 10'd7, 12'd7, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
        tick();
        idle();
        checkOutput("realloc_occ", 64'(occupancy),   64'd1);
        checkOutput("realloc_cv",  64'(commitValid), 64'd0);

        // Wrap: 20 single allocate/complete/commit rounds from a fresh ROB
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            t0 = 5'(i);
            p0 = 6'(i + 10);
            applyStimulus(2'b01, {5'd0, t0}, {6'd0, p0}, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
            tick();
            applyStimulus(2'b00, 10'd0, 12'd0, 2'b01, {5'd0, t0},
                          {32'd0, 32'hA000 + 32'(i)}, 2'b01, 2'b00);
            tick();
            idle();
            checkOutput("wrap_cv",     64'(commitValid),       64'd1);
            checkOutput("wrap_rd",     64'(commitRd[4:0]),     64'(t0));
            checkOutput("wrap_result", 64'(commitResult[31:0]), 64'hA000 + 64'(i));
            tick();
        end
        checkOutput("wrap_occ", 64'(occupancy), 64'd0);
        checkOutput("wrap_tag", 64'(dispTag),   64'({5'd21, 5'd20}));
        applyStimulus(2'b11, {5'd7, 5'd6}, {6'd9, 6'd8}, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
        tick();
        // Stale tag 4 shares slot 4 with live tag 20 but has the other wrap bit
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b01, {5'd0, 5'd4},
                      {32'd0, 32'h5555}, 2'b01, 2'b00);
        tick();
        idle();
        checkOutput("stale_cv",  64'(commitValid), 64'd0);
        checkOutput("stale_occ", 64'(occupancy),   64'd2);
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b01, {5'd0, 5'd20},
                      {32'd0, 32'h2020}, 2'b01, 2'b00);
        tick();
        idle();
        checkOutput("fresh_cv",     64'(commitValid),       64'd1);
        checkOutput("fresh_rd",     64'(commitRd[4:0]),     64'd6);
        checkOutput("fresh_result", 64'(commitResult[31:0]), 64'h2020);
        tick();
        checkOutput("fresh_occ", 64'(occupancy), 64'd1);

        // Reset with 10 live entries and a pending completion
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 10'd0, 12'd0, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
            tick();
        end
        applyStimulus(2'b01, 10'd0, 12'd0, 2'b00, 10'd0, 64'd0, 2'b00, 2'b00);
        tick();
        checkOutput("pre_rst_occ", 64'(occupancy), 64'd10);
        applyStimulus(2'b00, 10'd0, 12'd0, 2'b01, {5'd0, 5'd21},
                      {32'd0, 32'h7777}, 2'b01, 2'b00);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_occ",   64'(occupancy),   64'd0);
        checkOutput("mid_rst_cv",    64'(commitValid), 64'd0);
        checkOutput("mid_rst_ready", 64'(dispReady),   64'd1);
        checkOutput("mid_rst_tag",   64'(dispTag),     64'({5'd1, 5'd0}));
        rst = 1'b0;
        idle();
        tick();
        checkOutput("post_rst_cv",  64'(commitValid), 64'd0);
        checkOutput("post_rst_occ", 64'(occupancy),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
